// File: rtl/issueq_pkg.sv
// Shared sizing and entry types for the issue-queue free-entry allocator.
// An entry index is {block, local}, so block w owns entries [w*EPB, (w+1)*EPB).
package issueq_pkg;

  localparam int ENTRY_PER_BLOCK = 16;
  localparam int DISPATCH_WIDTH  = 4;
  localparam int ISSUE_WIDTH     = 4;
  localparam int SIZE_ISSUEQ     = DISPATCH_WIDTH * ENTRY_PER_BLOCK;
  localparam int SIZE_ISSUEQ_LOG = $clog2(SIZE_ISSUEQ);
  localparam int LOCAL_LOG       = $clog2(ENTRY_PER_BLOCK);
  localparam int BLOCK_LOG       = $clog2(DISPATCH_WIDTH);

  typedef logic [SIZE_ISSUEQ_LOG-1:0] iq_entry_t;
  typedef logic [LOCAL_LOG-1:0]       iq_local_t;
  typedef logic [SIZE_ISSUEQ_LOG:0]   iq_cnt_t;

  function automatic iq_entry_t glob_idx(input int blk, input iq_local_t loc);
    return {BLOCK_LOG'(blk), loc};
  endfunction

endpackage

// File: rtl/issueq_free_list_if.sv
// Dispatch and issue-free handshake bundle between the pipeline and the allocator.
// The pipeline side is the master; the allocator is the slave.
interface issueq_free_list_if;
  import issueq_pkg::*;

  logic                                dispatchValid_i;
  logic      [DISPATCH_WIDTH-1:0]      dispatchLaneValid_i;
  iq_entry_t [DISPATCH_WIDTH-1:0]      allocEntry_o;
  logic                                issueqReady_o;
  logic      [ISSUE_WIDTH-1:0]         freeValid_i;
  iq_entry_t [ISSUE_WIDTH-1:0]         freeEntry_i;

  modport master (
    output dispatchValid_i,
    output dispatchLaneValid_i,
    output freeValid_i,
    output freeEntry_i,
    input  allocEntry_o,
    input  issueqReady_o
  );

  modport slave (
    input  dispatchValid_i,
    input  dispatchLaneValid_i,
    input  freeValid_i,
    input  freeEntry_i,
    output allocEntry_o,
    output issueqReady_o
  );

endinterface

// File: rtl/iq_block_select.sv
// Lowest-set-bit encoder over one block of the free vector.
// Returns whether any entry is free and the block-local index of the lowest one.
module iq_block_select
  import issueq_pkg::*;
(
  input  logic [ENTRY_PER_BLOCK-1:0] i_vec,
  output logic                       o_found,
  output iq_local_t                  o_idx
);

  // Scan downward so the last hit written is the lowest index.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = ENTRY_PER_BLOCK - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = LOCAL_LOG'(i);
      end
    end
  end

endmodule

// File: rtl/issueq_free_list.sv
// Issue-queue free-entry allocator: one reserved candidate per dispatch lane,
// drawn from that lane's own block, with freed entries returned to the pool.
module issueq_free_list
  import issueq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  issueq_free_list_if.slave bus,
  output iq_cnt_t           freeCnt_o
);

  logic      [SIZE_ISSUEQ-1:0]    r_freeVec;
  iq_entry_t [DISPATCH_WIDTH-1:0] r_cand;
  logic      [DISPATCH_WIDTH-1:0] r_candValid;
  iq_cnt_t                        r_freeCnt;

  logic                           w_ready;
  logic      [DISPATCH_WIDTH-1:0] w_consume;
  logic      [DISPATCH_WIDTH-1:0] w_reload;
  logic      [DISPATCH_WIDTH-1:0] w_found;
  iq_local_t                      w_localIdx [DISPATCH_WIDTH];
  logic      [SIZE_ISSUEQ-1:0]    w_reloadMask;
  logic      [SIZE_ISSUEQ-1:0]    w_freedMask;
  logic      [SIZE_ISSUEQ-1:0]    w_freeVecNext;
  iq_cnt_t                        w_freeCntNext;

  function automatic iq_cnt_t popcnt_free(input logic [ISSUE_WIDTH-1:0] v);
    iq_cnt_t n;
    n = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) n = n + iq_cnt_t'(v[i]);
    return n;
  endfunction

  function automatic iq_cnt_t popcnt_lane(input logic [DISPATCH_WIDTH-1:0] v);
    iq_cnt_t n;
    n = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) n = n + iq_cnt_t'(v[i]);
    return n;
  endfunction

  assign w_ready   = &r_candValid;
  assign w_consume = {DISPATCH_WIDTH{bus.dispatchValid_i & w_ready}} & bus.dispatchLaneValid_i;
  assign w_reload  = ~r_candValid | w_consume;

  for (genvar w = 0; w < DISPATCH_WIDTH; w++) begin : g_sel
    iq_block_select u_sel (
      .i_vec   (r_freeVec[w*ENTRY_PER_BLOCK +: ENTRY_PER_BLOCK]),
      .o_found (w_found[w]),
      .o_idx   (w_localIdx[w])
    );
  end

  // Reload picks come only from the registered vector; freed entries wait a cycle.
  always_comb begin
    w_reloadMask = '0;
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      if (w_reload[w] && w_found[w]) w_reloadMask[glob_idx(w, w_localIdx[w])] = 1'b1;
    end
  end

  always_comb begin
    w_freedMask = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (bus.freeValid_i[k]) w_freedMask[bus.freeEntry_i[k]] = 1'b1;
    end
  end

  assign w_freeVecNext = (r_freeVec | w_freedMask) & ~w_reloadMask;
  assign w_freeCntNext = r_freeCnt + popcnt_free(bus.freeValid_i) - popcnt_lane(w_consume);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_freeVec   <= '1;
      r_cand      <= '0;
      r_candValid <= '0;
      r_freeCnt   <= iq_cnt_t'(SIZE_ISSUEQ);
    end else if (flush_i) begin
      r_freeVec   <= '1;
      r_candValid <= '0;
      r_freeCnt   <= iq_cnt_t'(SIZE_ISSUEQ);
    end else begin
      r_freeVec <= w_freeVecNext;
      r_freeCnt <= w_freeCntNext;
      for (int w = 0; w < DISPATCH_WIDTH; w++) begin
        if (w_reload[w]) begin
          r_candValid[w] <= w_found[w];
          if (w_found[w]) r_cand[w] <= glob_idx(w, w_localIdx[w]);
        end
      end
    end
  end

  assign bus.allocEntry_o  = r_cand;
  assign bus.issueqReady_o = w_ready;
  assign freeCnt_o         = r_freeCnt;

`ifndef SYNTHESIS
  logic w_badFree;
  logic w_dupFree;

  // A legal free names an in-flight entry: neither in the pool nor held as a candidate.
  always_comb begin
    w_badFree = 1'b0;
    w_dupFree = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (bus.freeValid_i[k]) begin
        if (r_freeVec[bus.freeEntry_i[k]]) w_badFree = 1'b1;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
          if (r_candValid[w] && (r_cand[w] == bus.freeEntry_i[k])) w_badFree = 1'b1;
        end
        for (int j = k + 1; j < ISSUE_WIDTH; j++) begin
          if (bus.freeValid_i[j] && (bus.freeEntry_i[j] == bus.freeEntry_i[k])) w_dupFree = 1'b1;
        end
      end
    end
  end

  a_no_bad_free: assert property (@(posedge clk) disable iff (!reset || flush_i) !w_badFree);
  a_no_dup_free: assert property (@(posedge clk) disable iff (!reset || flush_i) !w_dupFree);
`endif

endmodule

// File: doc/issueq_free_list.md
# issueq_free_list

Issue-queue free-entry allocator. It holds the IQ free vector and keeps one reserved candidate entry per dispatch lane. Each cycle it hands those candidates to dispatch, returns entries freed by issue to the free pool, and tracks the free-entry count. It sits between dispatch, which consumes `allocEntry_o`, and the issue/select stage, which returns freed entries on `freeEntry_i`.

## Interface
- `ENTRY_PER_BLOCK`, 16, entries per block; block w serves dispatch lane w only.
- `DISPATCH_WIDTH`, 4, dispatch lanes; also the block count.
- `ISSUE_WIDTH`, 4, free ports from issue.
- Derived: `SIZE_ISSUEQ = DISPATCH_WIDTH*ENTRY_PER_BLOCK` (64); `SIZE_ISSUEQ_LOG = $clog2(SIZE_ISSUEQ)` (6).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock, rising edge.
  - `reset`  in  1  asynchronous, active-low reset.
- Flush:
  - `flush_i`  in  1  pipeline flush; all entries become free.
- Dispatch:
  - `dispatchValid_i`  in  1  dispatch bundle present.
  - `dispatchLaneValid_i`  in  DISPATCH_WIDTH  lanes of the bundle that need an entry.
  - `allocEntry_o`  out  DISPATCH_WIDTH x SIZE_ISSUEQ_LOG  candidate entry for each lane, from `cand_q`.
  - `issueqReady_o`  out  1  all lane candidates are valid.
- Issue/free:
  - `freeValid_i`  in  ISSUE_WIDTH  free port valid.
  - `freeEntry_i`  in  ISSUE_WIDTH x SIZE_ISSUEQ_LOG  entry being freed.
- Status:
  - `freeCnt_o`  out  SIZE_ISSUEQ_LOG+1  entries not held by in-flight instructions.

## Operation
State:
- `freeVec_q[SIZE_ISSUEQ]`: a set bit means the entry is free and not reserved.
- `cand_q[w]` and `candValid_q[w]`: the reserved candidate for each lane.
- `freeCnt_q`.

Output and accept rules:
- `issueqReady_o = &candValid_q`.
- Lane w is consumed when `dispatchValid_i & issueqReady_o & dispatchLaneValid_i[w]`.
- Dispatch while `issueqReady_o=0` is ignored, and nothing is consumed.

Per-lane reload:
- Trigger: `!candValid_q[w]` or lane w consumed this cycle.
- Select the lowest-index set bit of `freeVec_q` within block w, i.e. entries `[w*EPB, (w+1)*EPB)`.
- If a bit is found: `cand_q[w]` takes that index, `candValid_q[w]` goes to 1, and the bit joins `reloadMask`.
- If the block is empty: `candValid_q[w]` goes to 0.
- Selection uses registered `freeVec_q` only. There is no same-cycle bypass of freed entries.
- A non-consumed valid candidate holds its value.

Free-vector update:
- `freedMask` is the OR of the one-hot `freeEntry_i[k]` for all valid k.
- `freeVec_d = (freeVec_q | freedMask) & ~reloadMask`.

Counter:
- `freeCnt_d = freeCnt_q + popcount(freeValid_i) - popcount(consumed lanes)`.
- It never leaves the range 0..SIZE_ISSUEQ in legal use.
- Candidate reservation does not change the count.

Flush:
- Highest priority after reset.
- `freeVec_q` becomes all ones, all `candValid_q` go to 0, and `freeCnt_q` becomes SIZE_ISSUEQ.
- Same-cycle dispatch and free inputs are ignored.

Illegal conditions, flagged by simulation assertions; RTL behaviour is undefined:
- freeing an entry that is already free or reserved;
- duplicate entries across free ports in one cycle.

## Timing
Reset values (asynchronous, while `reset=0`):
- `freeVec_q` all ones.
- `candValid_q` all 0 and `cand_q` all 0, so `allocEntry_o` reads 0.
- `issueqReady_o` = 0.
- `freeCnt_o` = 64.
- Reset mid-operation discards all state immediately.

After reset release:
- First clock edge: candidates load as 0, 16, 32, 48.
- `issueqReady_o` = 1 after that edge.

Dispatch:
- Zero-latency. `allocEntry_o` is valid in the accept cycle.
- The replacement candidate is visible after the next edge, so back-to-back full bundles sustain one bundle per cycle while blocks are non-empty.

Free-to-reuse latency when block w was empty:
- Free at cycle t sets the bit at edge t.
- The reload sees it at cycle t+1 and makes the candidate valid after edge t+1.
- Ready can therefore rise at t+2 at the earliest.

`freeCnt_o` updates one edge after the free or dispatch that causes it.

## Structure
- Shared package `issueq_pkg`: `ENTRY_PER_BLOCK`, `DISPATCH_WIDTH`, `ISSUE_WIDTH`, derived `SIZE_ISSUEQ`/`SIZE_ISSUEQ_LOG`, and typedef `iq_entry_t` (logic[SIZE_ISSUEQ_LOG-1:0]).
- One sub-module, `iq_block_select`: a combinational lowest-set-bit encoder with an ENTRY_PER_BLOCK-bit input, a found flag and a local index.
  - Instantiated DISPATCH_WIDTH times.
  - The global index is `{w, localIdx}`.
- Popcounts are local functions.

## Test plan
- **Reset release:** after the first edge → `allocEntry_o` = {0,16,32,48}, ready=1, `freeCnt_o`=64.
- **Two back-to-back full bundles:** → allocated {0,16,32,48} then {1,17,33,49}; `freeCnt_o`=56.
- **Partial bundle:** lane mask 4'b0101 → only lanes 0 and 2 advance (candidates {1,16,33,48}); count −2.
- **Drain block 0:** 16 lane-0 dispatches → ready=0. Dispatch while not ready → no change. Free entry 5 at cycle t → lane-0 candidate 5 and ready=1 at t+2.
- **Simultaneous events:** free of 2 entries plus a full-bundle dispatch in the same cycle → `freeCnt_o` net −2.
- **Flush and reset mid-run:** flush with pending free/dispatch inputs → count 64, ready 0 for one cycle, then candidates {0,16,32,48}. Async reset mid-run → outputs return to reset values without a clock edge.
